dcache_tagarray: RTL and testbench

DCACHE_TAGARRAY -- requirements
Module: dcache_tagarray

---
 rtl/dcache_tagarray.sv | 126 ++++++++++++
 tb/tb_dcache_tagarray.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tagarray.sv
// Data-cache tag array: per-set tags and valid bits for WAYS ways, one-cycle
// registered read port, masked write port, and an invalidate-all sweep FSM.
module dcache_tagarray #(
  parameter int TAGARRAY_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH           = 20,
  parameter int WAYS                = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           tagarray_rd_en,
  input  logic [TAGARRAY_ADDR_WIDTH-1:0] tagarray_rd_idx,
  output logic                           tagarray_rd_ready,
  output logic                           tagarray_resp_valid,
  output logic [WAYS*TAG_WIDTH-1:0]      tagarray_resp_tag,
  output logic [WAYS-1:0]                tagarray_resp_vld,
  input  logic                           tagarray_wr_en,
  input  logic [TAGARRAY_ADDR_WIDTH-1:0] tagarray_wr_idx,
  input  logic [WAYS-1:0]                tagarray_wr_way_mask,
  input  logic [TAG_WIDTH-1:0]           tagarray_wr_tag,
  input  logic                           tagarray_wr_vld,
  input  logic                           inv_all_req,
  output logic                           inv_busy
);

  localparam int NSETS = 2 ** TAGARRAY_ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic [TAGARRAY_ADDR_WIDTH-1:0]   sweep_cnt;
  logic                             sweep_last;

  // Tags are packed per set so each way is a constant-width part-select.
  logic [WAYS*TAG_WIDTH-1:0]        tag_mem [NSETS];
  logic [WAYS-1:0]                  vld_mem [NSETS];

  logic                             rd_fire;
  logic                             wr_fire;
  logic                             resp_load;
  logic [WAYS*TAG_WIDTH-1:0]        rd_tag_nxt;
  logic [WAYS-1:0]                  rd_vld_nxt;

  assign tagarray_rd_ready = (state == IDLE);
  assign inv_busy          = (state == SWEEP);
  assign rd_fire           = tagarray_rd_en && tagarray_rd_ready;
  assign wr_fire           = tagarray_wr_en && (state == IDLE);
  assign resp_load         = rd_fire && !flush;
  assign sweep_last        = (sweep_cnt == TAGARRAY_ADDR_WIDTH'(NSETS - 1));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: requests during a sweep are ignored; sweep ends after last set.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inv_all_req) state_nxt = SWEEP;
      SWEEP:   if (sweep_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep counter walks every set once; it wraps to zero on the last set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              sweep_cnt <= '0;
    else if (state == SWEEP)   sweep_cnt <= sweep_cnt + 1'b1;
    else                       sweep_cnt <= '0;
  end

  // Valid bits: cleared set-by-set during the sweep, otherwise masked writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < NSETS; s++) vld_mem[s] <= '0;
    end else if (state == SWEEP) begin
      vld_mem[sweep_cnt] <= '0;
    end else if (wr_fire) begin
      for (int unsigned w = 0; w < WAYS; w++)
        if (tagarray_wr_way_mask[w]) vld_mem[tagarray_wr_idx][w] <= tagarray_wr_vld;
    end
  end

  // Tag storage is not reset; valid bits mask stale contents.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int unsigned w = 0; w < WAYS; w++)
        if (tagarray_wr_way_mask[w])
          tag_mem[tagarray_wr_idx][w*TAG_WIDTH +: TAG_WIDTH] <= tagarray_wr_tag;
    end
  end

  // Read data with write-first bypass for masked ways of a same-index write.
  always_comb begin
    rd_tag_nxt = tag_mem[tagarray_rd_idx];
    rd_vld_nxt = vld_mem[tagarray_rd_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (wr_fire && (tagarray_wr_idx == tagarray_rd_idx) && tagarray_wr_way_mask[w]) begin
        rd_tag_nxt[w*TAG_WIDTH +: TAG_WIDTH] = tagarray_wr_tag;
        rd_vld_nxt[w]                        = tagarray_wr_vld;
      end
    end
  end

  // Response registers; data holds when no unflushed read was accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tagarray_resp_valid <= 1'b0;
      tagarray_resp_tag   <= '0;
      tagarray_resp_vld   <= '0;
    end else begin
      tagarray_resp_valid <= resp_load;
      if (resp_load) begin
        tagarray_resp_tag <= rd_tag_nxt;
        tagarray_resp_vld <= rd_vld_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dcache_tagarray.sv
// Self-checking bench for dcache_tagarray: directed scenarios plus random
// traffic compared against a set/way array model of the cache tag state.
module tb_dcache_tagarray;

  localparam int AW    = 6;
  localparam int TW    = 20;
  localparam int NW    = 2;
  localparam int NSETS = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              rd_en;
  logic [AW-1:0]     rd_idx;
  logic              rd_ready;
  logic              resp_valid;
  logic [NW*TW-1:0]  resp_tag;
  logic [NW-1:0]     resp_vld;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [NW-1:0]     wr_mask;
  logic [TW-1:0]     wr_tag;
  logic              wr_vld;
  logic              inv_req;
  logic              busy;

  always #5 clock = ~clock;

  dcache_tagarray #(
    .TAGARRAY_ADDR_WIDTH(AW),
    .TAG_WIDTH(TW),
    .WAYS(NW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .tagarray_rd_en(rd_en),
    .tagarray_rd_idx(rd_idx),
    .tagarray_rd_ready(rd_ready),
    .tagarray_resp_valid(resp_valid),
    .tagarray_resp_tag(resp_tag),
    .tagarray_resp_vld(resp_vld),
    .tagarray_wr_en(wr_en),
    .tagarray_wr_idx(wr_idx),
    .tagarray_wr_way_mask(wr_mask),
    .tagarray_wr_tag(wr_tag),
    .tagarray_wr_vld(wr_vld),
    .inv_all_req(inv_req),
    .inv_busy(busy)
  );

  // Reference model: contents of each set/way plus sweep cycles remaining.
  logic [TW-1:0] m_tag   [NSETS][NW];
  logic          m_vld   [NSETS][NW];
  logic          m_known [NSETS][NW];
  int            busy_left;
  logic          e_valid;
  logic [NW*TW-1:0] e_tag;
  logic [NW-1:0] e_vld;
  logic [NW-1:0] e_known;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", name, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NW*TW-1:0] kmask;
    for (int w = 0; w < NW; w++) kmask[w*TW +: TW] = {TW{e_known[w]}};
    chk("resp_valid", 64'(resp_valid), 64'(e_valid));
    chk("inv_busy",   64'(busy),       64'(busy_left > 0));
    chk("rd_ready",   64'(rd_ready),   64'(busy_left == 0));
    chk("resp_vld",   64'(resp_vld),   64'(e_vld));
    chk("resp_tag",   64'(resp_tag & kmask), 64'(e_tag & kmask));
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NW; w++) begin
        m_vld[s][w]   = 1'b0;
        m_known[s][w] = 1'b0;
      end
    busy_left = 0;
    e_valid   = 1'b0;
    e_tag     = '0;
    e_vld     = '0;
    e_known   = '1;
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check after.
  task automatic step(input logic rd, input int ridx, input logic fl,
                      input logic wr, input int widx, input logic [NW-1:0] m,
                      input logic [TW-1:0] t, input logic v, input logic inv);
    logic ready;
    rd_en = rd; rd_idx = ridx[AW-1:0]; flush = fl;
    wr_en = wr; wr_idx = widx[AW-1:0]; wr_mask = m; wr_tag = t; wr_vld = v;
    inv_req = inv;
    @(posedge clock);
    ready = (busy_left == 0);
    if (wr && ready)
      for (int w = 0; w < NW; w++)
        if (m[w]) begin
          m_tag[widx][w] = t; m_vld[widx][w] = v; m_known[widx][w] = 1'b1;
        end
    if (rd && ready && !fl) begin
      e_valid = 1'b1;
      for (int w = 0; w < NW; w++) begin
        e_tag[w*TW +: TW] = m_tag[ridx][w];
        e_vld[w]          = m_vld[ridx][w];
        e_known[w]        = m_known[ridx][w];
      end
    end else begin
      e_valid = 1'b0;
    end
    // No access is accepted mid-sweep, so clearing everything at sweep start
    // is observably the same as the set-by-set walk.
    if (busy_left > 0) busy_left--;
    else if (inv) begin
      busy_left = NSETS;
      for (int s = 0; s < NSETS; s++)
        for (int w = 0; w < NW; w++) m_vld[s][w] = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic rd(input int idx);
    step(1, idx, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic wr(input int idx, input logic [NW-1:0] m, input logic [TW-1:0] t, input logic v);
    step(0, 0, 0, 1, idx, m, t, v, 0);
  endtask

  initial begin
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NW; w++) m_tag[s][w] = '0;
    reset_n = 1'b0;
    rd_en = 0; rd_idx = '0; flush = 0; wr_en = 0; wr_idx = '0;
    wr_mask = '0; wr_tag = '0; wr_vld = 0; inv_req = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;

    // Write then read back in the following cycle.
    wr(5, 2'b01, 20'h12345, 1);
    rd(5);
    idle();

    // Same-cycle write and read of one set: new data for the masked way.
    step(1, 9, 0, 1, 9, 2'b10, 20'hABCDE, 1, 0);
    idle();
    // Different-index write and read in the same cycle.
    step(1, 5, 0, 1, 7, 2'b11, 20'h0F0F0, 1, 0);
    rd(7);
    idle();

    // Flushed read gives no response; the next unflushed one does.
    wr(3, 2'b11, 20'h33333, 1);
    step(1, 3, 1, 0, 0, '0, '0, 0, 0);
    rd(3);
    idle();

    // Ten back-to-back reads.
    for (int i = 0; i < 10; i++) rd(i);
    idle();

    // Fill every set, sweep, with reads/writes/re-requests thrown at it.
    for (int s = 0; s < NSETS; s++) wr(s, 2'b11, 20'($urandom), 1);
    step(0, 0, 0, 0, 0, '0, '0, 0, 1);
    for (int i = 0; i < NSETS + 4; i++)
      step($urandom_range(0, 1), $urandom_range(0, NSETS - 1), 0,
           $urandom_range(0, 1), $urandom_range(0, NSETS - 1), 2'($urandom),
           20'($urandom), 1, $urandom_range(0, 1) == 1 && i < NSETS - 1);
    for (int s = 0; s < NSETS; s++) rd(s);
    idle();

    // Random traffic with occasional sweeps and flushes.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7) == 0,
           $urandom_range(0, 1), $urandom_range(0, 15), 2'($urandom),
           20'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    while (busy_left > 0) idle();
    for (int s = 0; s < 16; s++) rd(s);

    // Reset in the middle of a sweep (counter at 20).
    for (int s = 0; s < NSETS; s++) wr(s, 2'b11, 20'($urandom), 1);
    rd(12);
    step(0, 0, 0, 0, 0, '0, '0, 0, 1);
    repeat (20) idle();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) rd($urandom_range(0, NSETS - 1));
    rd(0);
    rd(NSETS - 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
